pipe_memory: RTL and testbench

- Memory stage of the 5-stage RV32I pipeline. Consumes the *_M outputs of the EX/MEM register, runs loads and stores on a req/gnt/rvalid data-memory bus, aligns and extends load data, and holds the MEM/WB register that feeds writeback.
- Raises mem_busy to the hazard unit while a bus access is outstanding.

---
 rtl/pipe_memory.sv | 259 +++++++++++++++++++++++++
 tb/tb_pipe_memory.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_memory.sv
// RV32I memory stage: issues loads/stores on a req/gnt/rvalid data bus,
// aligns and extends load data, and owns the MEM/WB pipeline register.
module pipe_memory #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              reg_wr_M,
    input  logic              mem_wr_M,
    input  logic              mem_rd_M,
    input  logic [2:0]        mem_mask_M,
    input  logic [1:0]        sel_wb_M,
    input  logic [31:0]       alu_o_M,
    input  logic [31:0]       wr_data_M,
    input  logic [4:0]        rd_M,
    input  logic [31:0]       PC4_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_busy,
    output logic              misalign_M,
    output logic              reg_wr_W,
    output logic [1:0]        sel_wb_W,
    output logic [31:0]       alu_o_W,
    output logic [31:0]       rd_data_W,
    output logic [4:0]        rd_W,
    output logic [31:0]       PC4_W
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [3:0] store_be_f(input logic [2:0] mask, input logic [1:0] off);
        case (mask[1:0])
            2'b00:   store_be_f = 4'b0001 << off;
            2'b01:   store_be_f = off[1] ? 4'b1100 : 4'b0011;
            default: store_be_f = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata_f(input logic [2:0] mask, input logic [31:0] data);
        case (mask[1:0])
            2'b00:   store_wdata_f = {4{data[7:0]}};
            2'b01:   store_wdata_f = {2{data[15:0]}};
            default: store_wdata_f = data;
        endcase
    endfunction

    function automatic logic [31:0] load_ext_f(input logic [2:0] mask, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (mask)
            3'b000:  load_ext_f = {{24{b[7]}}, b};
            3'b001:  load_ext_f = {{16{h[15]}}, h};
            3'b100:  load_ext_f = {24'd0, b};
            3'b101:  load_ext_f = {16'd0, h};
            default: load_ext_f = rdata;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic                we_q;
    logic [2:0]          mask_q;
    logic [1:0]          off_q;
    logic                flush_q, flush_d;
    logic [31:0]         buf_q;

    logic                reg_wr_q, reg_wr_d;
    logic [1:0]          sel_wb_q, sel_wb_d;
    logic [31:0]         alu_q, alu_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic [4:0]          rd_q, rd_d;
    logic [31:0]         pc4_q, pc4_d;

    logic                acc_s, complete_s, busy_s, drop_s, misalign_s;
    logic [31:0]         ld_data_s;
    state_t              finish_s;

    // Bus drive, completion detection, busy and access FSM next state.
    always_comb begin
        misalign_s = (mem_rd_M | mem_wr_M) &
                     (((mem_mask_M[1:0] == 2'b01) & alu_o_M[0]) |
                      ((mem_mask_M[1:0] == 2'b10) & (alu_o_M[1:0] != 2'b00)));
        acc_s      = (mem_rd_M | mem_wr_M) & ~misalign_s & ~flush & ~rst;
        finish_s   = (stall & ~(flush_q | flush)) ? DONE : IDLE;

        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'd0;
        complete_s = 1'b0;
        busy_s     = 1'b0;
        ld_data_s  = 32'd0;
        state_d    = state_q;

        case (state_q)
            IDLE: begin
                if (acc_s) begin
                    dmem_req   = 1'b1;
                    dmem_we    = mem_wr_M;
                    dmem_addr  = {alu_o_M[ADDR_W-1:2], 2'b00};
                    dmem_be    = mem_wr_M ? store_be_f(mem_mask_M, alu_o_M[1:0]) : 4'b1111;
                    dmem_wdata = mem_wr_M ? store_wdata_f(mem_mask_M, wr_data_M) : 32'd0;
                    complete_s = dmem_gnt & mem_wr_M;
                    busy_s     = ~complete_s;
                    if (!dmem_gnt) begin
                        state_d = REQ;
                    end else if (mem_wr_M) begin
                        state_d = finish_s;
                    end else begin
                        state_d = RSP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_be    = be_q;
                dmem_wdata = wdata_q;
                complete_s = dmem_gnt & we_q;
                busy_s     = ~complete_s;
                if (!dmem_gnt) begin
                    state_d = REQ;
                end else if (we_q) begin
                    state_d = finish_s;
                end else begin
                    state_d = RSP;
                end
            end
            RSP: begin
                complete_s = dmem_rvalid;
                busy_s     = ~dmem_rvalid;
                if (dmem_rvalid) begin
                    ld_data_s = load_ext_f(mask_q, off_q, dmem_rdata);
                    state_d   = finish_s;
                end else begin
                    state_d = RSP;
                end
            end
            DONE: begin
                ld_data_s = buf_q;
                state_d   = stall ? DONE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush seen mid-transaction discards the result once the bus is done.
        drop_s  = complete_s & flush_q;
        flush_d = ((state_d == REQ) || (state_d == RSP)) ? (flush_q | flush) : 1'b0;
    end

    // MEM/WB next state: stall holds, flush/drop/busy bubble, else capture.
    always_comb begin
        reg_wr_d  = reg_wr_q;
        sel_wb_d  = sel_wb_q;
        alu_d     = alu_q;
        rd_data_d = rd_data_q;
        rd_d      = rd_q;
        pc4_d     = pc4_q;
        if (stall) begin
            reg_wr_d = reg_wr_q;
        end else if (flush | drop_s | busy_s) begin
            reg_wr_d  = 1'b0;
            sel_wb_d  = 2'b00;
            alu_d     = 32'd0;
            rd_data_d = 32'd0;
            rd_d      = 5'd0;
            pc4_d     = 32'd0;
        end else begin
            reg_wr_d  = reg_wr_M & ~misalign_s;
            sel_wb_d  = sel_wb_M;
            alu_d     = alu_o_M;
            rd_data_d = misalign_s ? 32'd0 : ld_data_s;
            rd_d      = rd_M;
            pc4_d     = PC4_M;
        end
    end

    // Access FSM, held bus request fields and load buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            mask_q  <= 3'b000;
            off_q   <= 2'b00;
            flush_q <= 1'b0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            if (state_q == IDLE && acc_s) begin
                addr_q  <= dmem_addr;
                be_q    <= dmem_be;
                wdata_q <= dmem_wdata;
                we_q    <= dmem_we;
                mask_q  <= mem_mask_M;
                off_q   <= alu_o_M[1:0];
            end
            if (complete_s) begin
                buf_q <= ld_data_s;
            end
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wr_q  <= 1'b0;
            sel_wb_q  <= 2'b00;
            alu_q     <= 32'd0;
            rd_data_q <= 32'd0;
            rd_q      <= 5'd0;
            pc4_q     <= 32'd0;
        end else begin
            reg_wr_q  <= reg_wr_d;
            sel_wb_q  <= sel_wb_d;
            alu_q     <= alu_d;
            rd_data_q <= rd_data_d;
            rd_q      <= rd_d;
            pc4_q     <= pc4_d;
        end
    end

    assign mem_busy   = busy_s;
    assign misalign_M = misalign_s;
    assign reg_wr_W   = reg_wr_q;
    assign sel_wb_W   = sel_wb_q;
    assign alu_o_W    = alu_q;
    assign rd_data_W  = rd_data_q;
    assign rd_W       = rd_q;
    assign PC4_W      = pc4_q;

endmodule

// File: tb/tb_pipe_memory.sv
// Directed self-checking bench for pipe_memory: loads, stores, misalign,
// stall/DONE hold, flush during a response and async reset mid-request.
module tb_pipe_memory;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        reg_wr_M, mem_wr_M, mem_rd_M;
    logic [2:0]  mem_mask_M;
    logic [1:0]  sel_wb_M;
    logic [31:0] alu_o_M, wr_data_M, PC4_M;
    logic [4:0]  rd_M;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        mem_busy, misalign_M, reg_wr_W;
    logic [1:0]  sel_wb_W;
    logic [31:0] alu_o_W, rd_data_W, PC4_W;
    logic [4:0]  rd_W;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] la [5] = '{32'h0000_0103, 32'h0000_0202, 32'h0000_0202, 32'h0000_0101, 32'h0000_0008};
    logic [2:0]  lm [5] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010};
    logic [31:0] lr [5] = '{32'h80FF_0000, 32'hBEEF_1234, 32'hBEEF_1234, 32'h0000_9A00, 32'h1234_5678};
    logic [31:0] le [5] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_009A, 32'h1234_5678};

    pipe_memory #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .reg_wr_M(reg_wr_M), .mem_wr_M(mem_wr_M), .mem_rd_M(mem_rd_M),
        .mem_mask_M(mem_mask_M), .sel_wb_M(sel_wb_M), .alu_o_M(alu_o_M),
        .wr_data_M(wr_data_M), .rd_M(rd_M), .PC4_M(PC4_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_busy(mem_busy), .misalign_M(misalign_M),
        .reg_wr_W(reg_wr_W), .sel_wb_W(sel_wb_W), .alu_o_W(alu_o_W),
        .rd_data_W(rd_data_W), .rd_W(rd_W), .PC4_W(PC4_W)
    );

    always #5 clk = ~clk;

    task automatic clear_m();
        reg_wr_M = 1'b0; mem_wr_M = 1'b0; mem_rd_M = 1'b0; mem_mask_M = 3'b000;
        sel_wb_M = 2'b00; alu_o_M = 32'd0; wr_data_M = 32'd0; rd_M = 5'd0; PC4_M = 32'd0;
    endtask

    task automatic set_m(input logic rw, input logic rd, input logic wr, input logic [2:0] mask,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] dst);
        reg_wr_M = rw; mem_rd_M = rd; mem_wr_M = wr; mem_mask_M = mask;
        alu_o_M = addr; wr_data_M = wd; rd_M = dst; sel_wb_M = 2'b01; PC4_M = 32'h0000_0044;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; clear_m();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", dmem_req); end
        n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", mem_busy); end
        n_cmp++; if (reg_wr_W !== 1'b0) begin n_err++; $display("FAIL rst_reg_wr_W got %b want 0", reg_wr_W); end
        n_cmp++; if (rd_data_W !== 32'd0) begin n_err++; $display("FAIL rst_rd_data_W got %h want 0", rd_data_W); end
        n_cmp++; if (PC4_W !== 32'd0) begin n_err++; $display("FAIL rst_PC4_W got %h want 0", PC4_W); end
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        reg_wr_M = 1'b1; sel_wb_M = 2'b10; alu_o_M = 32'hDEAD_0004; rd_M = 5'd3; PC4_M = 32'h0000_0100;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL alu_req got %b want 0", dmem_req); end
        @(posedge clk); #1;
        n_cmp++; if (reg_wr_W !== 1'b1) begin n_err++; $display("FAIL alu_reg_wr_W got %b want 1", reg_wr_W); end
        n_cmp++; if (alu_o_W !== 32'hDEAD_0004) begin n_err++; $display("FAIL alu_o_W got %h want dead0004", alu_o_W); end
        n_cmp++; if (sel_wb_W !== 2'b10) begin n_err++; $display("FAIL alu_sel_wb_W got %b want 10", sel_wb_W); end
        n_cmp++; if (PC4_W !== 32'h0000_0100) begin n_err++; $display("FAIL alu_PC4_W got %h want 100", PC4_W); end
        n_cmp++; if (rd_data_W !== 32'd0) begin n_err++; $display("FAIL alu_rd_data_W got %h want 0", rd_data_W); end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (alu_o_W !== 32'd0) begin n_err++; $display("FAIL flush_alu_o_W got %h want 0", alu_o_W); end
        n_cmp++; if (reg_wr_W !== 1'b0) begin n_err++; $display("FAIL flush_reg_wr_W got %b want 0", reg_wr_W); end
        @(negedge clk); flush = 1'b0; clear_m();
    endtask

    task automatic test_load_extend();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_m(1'b1, 1'b1, 1'b0, lm[i], la[i], 32'd0, 5'(i + 1));
            dmem_gnt = 1'b1;
            #1;
            n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL ld%0d_req got %b want 1", i, dmem_req); end
            n_cmp++; if (dmem_addr !== (la[i] & 32'hFFFF_FFFC)) begin n_err++; $display("FAIL ld%0d_addr got %h want %h", i, dmem_addr, la[i] & 32'hFFFF_FFFC); end
            n_cmp++; if (dmem_be !== 4'b1111) begin n_err++; $display("FAIL ld%0d_be got %b want 1111", i, dmem_be); end
            n_cmp++; if (mem_busy !== 1'b1) begin n_err++; $display("FAIL ld%0d_busy_issue got %b want 1", i, mem_busy); end
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = lr[i];
            #1;
            n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL ld%0d_busy_rsp got %b want 0", i, mem_busy); end
            n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL ld%0d_req_rsp got %b want 0", i, dmem_req); end
            @(posedge clk); #1;
            n_cmp++; if (rd_data_W !== le[i]) begin n_err++; $display("FAIL ld%0d_rd_data_W got %h want %h", i, rd_data_W, le[i]); end
            n_cmp++; if (reg_wr_W !== 1'b1) begin n_err++; $display("FAIL ld%0d_reg_wr_W got %b want 1", i, reg_wr_W); end
            @(negedge clk);
            dmem_rvalid = 1'b0; clear_m();
        end
    endtask

    task automatic test_store_delayed();
        logic exp_busy;
        @(negedge clk);
        set_m(1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 5'd0);
        dmem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            dmem_gnt = (i == 3);
            exp_busy = (i < 3);
            #1;
            n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL sb%0d_req got %b want 1", i, dmem_req); end
            n_cmp++; if (dmem_be !== 4'b0010) begin n_err++; $display("FAIL sb%0d_be got %b want 0010", i, dmem_be); end
            n_cmp++; if (dmem_wdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb%0d_wdata got %h want a5a5a5a5", i, dmem_wdata); end
            n_cmp++; if (dmem_addr !== 32'h0000_0010) begin n_err++; $display("FAIL sb%0d_addr got %h want 10", i, dmem_addr); end
            n_cmp++; if (mem_busy !== exp_busy) begin n_err++; $display("FAIL sb%0d_busy got %b want %b", i, mem_busy, exp_busy); end
        end
        @(posedge clk); #1;
        n_cmp++; if (reg_wr_W !== 1'b0) begin n_err++; $display("FAIL sb_reg_wr_W got %b want 0", reg_wr_W); end
        @(negedge clk);
        dmem_gnt = 1'b0; clear_m();
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL sb_req_after got %b want 0", dmem_req); end
    endtask

    task automatic test_store_lanes();
        logic [31:0] sa [2] = '{32'h0000_0022, 32'h0000_0030};
        logic [2:0]  sm [2] = '{3'b001, 3'b010};
        logic [31:0] sd [2] = '{32'h0000_1234, 32'h89AB_CDEF};
        logic [3:0]  eb [2] = '{4'b1100, 4'b1111};
        logic [31:0] ew [2] = '{32'h1234_1234, 32'h89AB_CDEF};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_m(1'b0, 1'b0, 1'b1, sm[i], sa[i], sd[i], 5'd0);
            dmem_gnt = 1'b1;
            #1;
            n_cmp++; if (dmem_be !== eb[i]) begin n_err++; $display("FAIL st%0d_be got %b want %b", i, dmem_be, eb[i]); end
            n_cmp++; if (dmem_wdata !== ew[i]) begin n_err++; $display("FAIL st%0d_wdata got %h want %h", i, dmem_wdata, ew[i]); end
            n_cmp++; if (dmem_we !== 1'b1) begin n_err++; $display("FAIL st%0d_we got %b want 1", i, dmem_we); end
            n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL st%0d_busy got %b want 0", i, mem_busy); end
            @(negedge clk);
            dmem_gnt = 1'b0; clear_m();
        end
    endtask

    task automatic test_misalign();
        logic [31:0] ma [3] = '{32'h0000_0006, 32'h0000_0003, 32'h0000_0002};
        logic [2:0]  mm [3] = '{3'b010, 3'b001, 3'b010};
        logic        mw [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_m(1'b1, ~mw[i], mw[i], mm[i], ma[i], 32'hFFFF_FFFF, 5'd4);
            dmem_gnt = 1'b0;
            #1;
            n_cmp++; if (misalign_M !== 1'b1) begin n_err++; $display("FAIL mis%0d_flag got %b want 1", i, misalign_M); end
            n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL mis%0d_req got %b want 0", i, dmem_req); end
            n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL mis%0d_busy got %b want 0", i, mem_busy); end
            @(posedge clk); #1;
            n_cmp++; if (reg_wr_W !== 1'b0) begin n_err++; $display("FAIL mis%0d_reg_wr_W got %b want 0", i, reg_wr_W); end
            n_cmp++; if (rd_data_W !== 32'd0) begin n_err++; $display("FAIL mis%0d_rd_data_W got %h want 0", i, rd_data_W); end
            @(negedge clk); clear_m();
        end
    endtask

    task automatic test_stall_done();
        @(negedge clk);
        set_m(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 5'd7);
        dmem_gnt = 1'b1;
        #1;
        n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL stl_req_issue got %b want 1", dmem_req); end
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D; stall = 1'b1;
        #1;
        n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL stl_busy_cmpl got %b want 0", mem_busy); end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL stl_req_done got %b want 0", dmem_req); end
        n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL stl_busy_done got %b want 0", mem_busy); end
        n_cmp++; if (reg_wr_W !== 1'b0) begin n_err++; $display("FAIL stl_hold_reg_wr_W got %b want 0", reg_wr_W); end
        @(negedge clk);
        stall = 1'b0;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL stl_reissue got %b want 0", dmem_req); end
        @(posedge clk); #1;
        n_cmp++; if (rd_data_W !== 32'hCAFE_F00D) begin n_err++; $display("FAIL stl_rd_data_W got %h want cafef00d", rd_data_W); end
        n_cmp++; if (reg_wr_W !== 1'b1) begin n_err++; $display("FAIL stl_reg_wr_W got %b want 1", reg_wr_W); end
        n_cmp++; if (rd_W !== 5'd7) begin n_err++; $display("FAIL stl_rd_W got %0d want 7", rd_W); end
        @(negedge clk); clear_m();
    endtask

    task automatic test_flush_rsp();
        @(negedge clk);
        set_m(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'd0, 5'd9);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; flush = 1'b1;
        #1;
        n_cmp++; if (mem_busy !== 1'b1) begin n_err++; $display("FAIL fl_busy_flush got %b want 1", mem_busy); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++; if (mem_busy !== 1'b1) begin n_err++; $display("FAIL fl_busy_wait got %b want 1", mem_busy); end
        n_cmp++; if (reg_wr_W !== 1'b0) begin n_err++; $display("FAIL fl_reg_wr_W_mid got %b want 0", reg_wr_W); end
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL fl_busy_rvalid got %b want 0", mem_busy); end
        @(posedge clk); #1;
        n_cmp++; if (reg_wr_W !== 1'b0) begin n_err++; $display("FAIL fl_reg_wr_W got %b want 0", reg_wr_W); end
        n_cmp++; if (rd_data_W !== 32'd0) begin n_err++; $display("FAIL fl_rd_data_W got %h want 0", rd_data_W); end
        n_cmp++; if (rd_W !== 5'd0) begin n_err++; $display("FAIL fl_rd_W got %0d want 0", rd_W); end
        @(negedge clk);
        dmem_rvalid = 1'b0; clear_m();
        #1;
        n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL fl_busy_idle got %b want 0", mem_busy); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        set_m(1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0060, 32'h0000_0001, 5'd0);
        dmem_gnt = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL ar_req_held got %b want 1", dmem_req); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL ar_req_drop got %b want 0", dmem_req); end
        n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got %b want 0", mem_busy); end
        clear_m();
        @(negedge clk);
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_1234;
        #1;
        n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL ar_busy_late got %b want 0", mem_busy); end
        @(posedge clk); #1;
        n_cmp++; if (rd_data_W !== 32'd0) begin n_err++; $display("FAIL ar_rd_data_W got %h want 0", rd_data_W); end
        @(negedge clk); dmem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_extend();
        test_store_delayed();
        test_store_lanes();
        test_misalign();
        test_stall_done();
        test_flush_rsp();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
